// File: rtl/falu_wb_buffer_pkg.sv
// falu_wb_buffer_pkg: shared FALU writeback bus widths, entry layout and kill-mask helpers
package falu_wb_buffer_pkg;
  localparam int SPEC_STATES       = 4;
  localparam int RESULT_LEN        = 72;
  localparam int RESULT_VALID      = 71;
  localparam int WAKEUP_RESP_LEN   = 14;
  localparam int WAKEUP_RESP_VALID = 13;
  typedef struct packed {
    logic [RESULT_LEN-1:0]      result;
    logic [WAKEUP_RESP_LEN-1:0] wakeup;
    logic [SPEC_STATES-1:0]     killmask;
  } wb_entry_t;
  localparam int WB_ENTRY_LEN = $bits(wb_entry_t);
  function automatic logic mask_hit(input logic en, input logic [SPEC_STATES-1:0] m,
                                    input logic [SPEC_STATES-1:0] v);
    return en & (|(m & v));
  endfunction
  function automatic logic [SPEC_STATES-1:0] mask_resolve(input logic en, input logic [SPEC_STATES-1:0] m,
                                                          input logic [SPEC_STATES-1:0] r);
    return en ? (m & ~r) : m;
  endfunction
endpackage

// File: rtl/falu_wb_entry.sv
// falu_wb_entry: one queue slot holding an entry and evaluating kill/resolve on its mask
module falu_wb_entry
  import falu_wb_buffer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_d,
  input  logic [WB_ENTRY_LEN-1:0] ent_d,
  input  logic                    kill_en,
  input  logic [SPEC_STATES-1:0]  kill_mask,
  input  logic                    resolve_en,
  input  logic [SPEC_STATES-1:0]  resolve_mask,
  output logic                    valid_q,
  output logic                    killed,
  output logic [WB_ENTRY_LEN-1:0] ent_resolved
);
  logic [WB_ENTRY_LEN-1:0] ent_q;
  wb_entry_t cur;
  // slot storage, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end
  // kill test on the stored mask, and the mask as it will look once resolved
  always_comb begin
    cur          = ent_q;
    killed       = valid_q & mask_hit(kill_en, cur.killmask, kill_mask);
    cur.killmask = mask_resolve(resolve_en, cur.killmask, resolve_mask);
    ent_resolved = cur;
  end
endmodule

// File: rtl/falu_wb_buffer.sv
// falu_wb_buffer: compacting FIFO holding FALU results/wakeups until the writeback arbiter grants them
module falu_wb_buffer
  import falu_wb_buffer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Flush,
  input  logic                              Kill_Enable,
  input  logic [SPEC_STATES-1:0]            Kill_VKillMask,
  input  logic                              Resolve_Enable,
  input  logic [SPEC_STATES-1:0]            Resolve_Mask,
  input  logic [RESULT_LEN-1:0]             In_ResultBus,
  input  logic [WAKEUP_RESP_LEN-1:0]        In_WakeupResp,
  input  logic [SPEC_STATES-1:0]            In_KillMask,
  output logic                              Out_Valid,
  input  logic                              Out_Grant,
  output logic [RESULT_LEN-1:0]             Out_ResultBus,
  output logic [WAKEUP_RESP_LEN-1:0]        Out_WakeupResp,
  output logic                              Stall,
  output logic [$clog2(DEPTH):0]            Count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0]        valid_q, valid_d, killed;
  logic [WB_ENTRY_LEN-1:0] ent_d [DEPTH];
  logic [WB_ENTRY_LEN-1:0] ent_res [DEPTH];
  logic [CW-1:0]           count_q, count_d;
  logic                    push, pop;
  wb_entry_t               in_ent;
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    falu_wb_entry u_entry (
      .clk          (clk),
      .rst          (rst),
      .valid_d      (valid_d[i]),
      .ent_d        (ent_d[i]),
      .kill_en      (Kill_Enable),
      .kill_mask    (Kill_VKillMask),
      .resolve_en   (Resolve_Enable),
      .resolve_mask (Resolve_Mask),
      .valid_q      (valid_q[i]),
      .killed       (killed[i]),
      .ent_resolved (ent_res[i])
    );
  end
  // head presentation and handshake; only registered state, kill and flush reach the outputs
  always_comb begin
    push           = In_WakeupResp[WAKEUP_RESP_VALID] | In_ResultBus[RESULT_VALID];
    Out_Valid      = valid_q[0] & ~killed[0] & ~Flush;
    pop            = Out_Valid & Out_Grant;
    Out_ResultBus  = Out_Valid ? ent_res[0][WB_ENTRY_LEN-1 -: RESULT_LEN] : '0;
    Out_WakeupResp = Out_Valid ? ent_res[0][SPEC_STATES +: WAKEUP_RESP_LEN] : '0;
    Stall          = (DEPTH - int'(count_q)) <= STALL_MARGIN;
    Count          = count_q;
  end
  // next queue: drop popped head and killed entries, compact, append, with masks already resolved
  always_comb begin
    valid_d = '0;
    ent_d   = '{default: '0};
    count_d = '0;
    in_ent  = '{result: In_ResultBus, wakeup: In_WakeupResp,
                killmask: mask_resolve(Resolve_Enable, In_KillMask, Resolve_Mask)};
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && !killed[k] && !(k == 0 && pop)) begin
        valid_d[count_d[IW-1:0]] = 1'b1;
        ent_d[count_d[IW-1:0]]   = ent_res[k];
        count_d                  = count_d + CW'(1);
      end
    end
    if (push && !mask_hit(Kill_Enable, In_KillMask, Kill_VKillMask) && count_d < CW'(DEPTH)) begin
      valid_d[count_d[IW-1:0]] = 1'b1;
      ent_d[count_d[IW-1:0]]   = in_ent;
      count_d                  = count_d + CW'(1);
    end
    if (Flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end
  // occupancy register mirrors the number of valid slots after the update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end
  // a completion arriving with no room and no departing head would be lost
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && count_q == CW'(DEPTH) && !pop && !Flush));
endmodule

// File: doc/falu_wb_buffer.md
Name: falu_wb_buffer

Overview:
- Result/wakeup holding queue directly downstream of the FP ALU.
- Captures each completed FALU result bus and wakeup response, plus the issuing uop's kill mask, into a small compacting FIFO.
- Presents the oldest surviving entry to the shared writeback/wakeup arbiter with a valid/grant handshake.
- Squashes entries on branch mispredict or flush, and back-pressures the scheduler so FALU completions are never dropped.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- STALL_MARGIN, 1, free slots reserved for an in-flight FALU op; Stall asserts when free slots <= STALL_MARGIN.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low.
- Flush  in  1  pipeline flush; empties queue.
- Kill_Enable  in  1  branch mispredict kill strobe.
- Kill_VKillMask  in  `SPEC_STATES  speculative states being killed.
- Resolve_Enable  in  1  branch resolved correctly.
- Resolve_Mask  in  `SPEC_STATES  spec-state bits to clear from stored kill masks.
- In_ResultBus  in  `RESULT_LEN  FALU ResultBus output.
- In_WakeupResp  in  `WAKEUP_RESP_LEN  FALU WakeupResp output.
- In_KillMask  in  `SPEC_STATES  kill mask of the uop currently in FALU.
- Out_Valid  out  1  head entry valid toward arbiter.
- Out_Grant  in  1  arbiter accepts head this cycle.
- Out_ResultBus  out  `RESULT_LEN  head result; all-zero when Out_Valid=0.
- Out_WakeupResp  out  `WAKEUP_RESP_LEN  head wakeup; all-zero when Out_Valid=0.
- Stall  out  1  scheduler must not issue a new uop to FALU.
- Count  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters.

Behaviour:
- Reset (rst=0, async):
  - All entries invalid; Count=0.
  - Out_Valid=0; Out_* = 0; Stall=0.
- Push condition: push = In_WakeupResp[`WAKEUP_RESP_VALID] | In_ResultBus[`RESULT_VALID].
  - The entry stores ResultBus, WakeupResp and KillMask.
  - The entry is written at the rising edge of the cycle in which push is high.
- Latency: minimum 1 cycle. A push at cycle N gives Out_Valid=1 in cycle N+1 if the queue was empty. No combinational bypass from In_* to Out_*.
- Ordering: strict age order. The queue is compacting: entry 0 is always the oldest, and survivors shift toward 0.
- Head kill: headKilled = Kill_Enable & |(entry0.KillMask & Kill_VKillMask).
  - Out_Valid = entry0.valid & ~headKilled & ~Flush.
- Pop: pop = Out_Valid & Out_Grant. Out_Grant while Out_Valid=0 is ignored.
- Per-cycle next-state order, all evaluated on the current cycle's inputs:
  1. Drop head if pop.
  2. Drop every entry whose KillMask & Kill_VKillMask != 0 when Kill_Enable=1.
  3. Compact survivors.
  4. Append incoming push unless Flush, or unless Kill_Enable & |(In_KillMask & Kill_VKillMask).
  5. For survivors and the appended entry, KillMask &= ~Resolve_Mask when Resolve_Enable=1.
- Kill and resolve on the same bit in the same cycle is illegal; Kill takes priority.
- Flush: next state is empty, regardless of push or pop. Out_Valid=0 in the flush cycle.
- Full:
  - Count==DEPTH with a push and no pop is a protocol violation: simulation assertion; the entry is dropped.
  - Push with simultaneous pop while full is legal.
- Stall = (DEPTH - Count) <= STALL_MARGIN. Registered-state based only, with no combinational path from In_*.
- Exceptions: WakeupResp exception/ecause/metadata pass through unmodified. The buffer never interprets payload beyond the valid bits.
- Count is the registered occupancy after the update.

Decomposition:
- Entry struct layout (result, wakeup, killmask) and its width constant go in the shared core defines package, next to `RESULT_LEN / `WAKEUP_RESP_LEN.
- One natural sub-module: falu_wb_entry. It holds one slot's registers and computes kill/resolve on its mask. Instantiate DEPTH times under the compaction mux in falu_wb_buffer.

Test Plan:
- Single push, PRD=7, value 0x3FF0000000000000, Out_Grant=1 held → Out_Valid=1 exactly one cycle later, matching payload; Count returns 0 the cycle after.
- Four back-to-back pushes, Out_Grant=0, DEPTH=4 → Stall=1 once Count=3; then grant every cycle → outputs drain in push order (PRD 1,2,3,4).
- Queue holds masks 0001, 0010, 0001; Kill_Enable=1, Kill_VKillMask=0001 → next cycle Count=1 and head is the 0010 entry. Head killed in the kill cycle gives Out_Valid=0 even with Out_Grant=1.
- Push with In_KillMask=0100 while Kill_VKillMask=0100 → not enqueued. Resolve_Mask=0010 on stored mask 0010 → stored mask 0000, and a later kill of 0010 leaves the entry intact.
- Queue of 3 plus push, pop and Flush all in one cycle → next cycle Count=0, Out_Valid=0, Stall=0.
- rst asserted low mid-drain, asynchronous to clk → Out_Valid and Out_* go 0 immediately; Count=0 after rst release.
